// File: rtl/huffman_packer.sv
// huffman_packer: latches a six-entry Huffman code table, then serializes the
// code of each incoming gray symbol (root bit first) into packed bytes, MSB
// first. After NUM_PIX symbols the final byte is zero-padded and flagged.
// Optional feature macro: HUFF_PACK_BITCNT_EN adds the total_bits output,
// a count of emitted code bits for the current image (pad bits excluded).
module huffman_packer #(
   parameter int NUM_PIX = 100,
   parameter int CNT_W   = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       code_valid,
   input  logic [7:0] HC1,
   input  logic [7:0] HC2,
   input  logic [7:0] HC3,
   input  logic [7:0] HC4,
   input  logic [7:0] HC5,
   input  logic [7:0] HC6,
   input  logic [7:0] M1,
   input  logic [7:0] M2,
   input  logic [7:0] M3,
   input  logic [7:0] M4,
   input  logic [7:0] M5,
   input  logic [7:0] M6,
   input  logic       sym_valid,
   input  logic [7:0] sym_data,
   output logic       sym_ready,
   input  logic       byte_ready,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_last,
   output logic       done,
`ifdef HUFF_PACK_BITCNT_EN
   output logic       err,
   output logic [9:0] total_bits
`else
   output logic       err
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, READY, SHIFT, HOLD, FLUSH, DONE} state_t;

   state_t state, next_state;

   logic [7:0]       hc_tab [6];
   logic [3:0]       len_tab [6];
   logic [7:0]       cur_code;
   logic [3:0]       bits_left;
   logic [7:0]       byte_reg;
   logic [2:0]       bitcnt;
   logic [CNT_W-1:0] sym_cnt;
   logic             last_byte;
   logic [2:0]       sel_idx;
   logic [2:0]       bit_pos;
   logic             last_bit;
   logic             byte_full;
   logic             cnt_hit;
   logic             table_load;

   // Code length is the position of the highest mask bit plus one.
   function automatic logic [3:0] code_len(input logic [7:0] m);
      code_len = 4'd0;
      for (int i = 0; i < 8; i++)
         if (m[i]) code_len = 4'(i + 1);
   endfunction

   assign last_bit   = (bits_left == 4'd1);
   assign byte_full  = (bitcnt == 3'd7);
   assign cnt_hit    = (sym_cnt == CNT_W'(NUM_PIX - 1));
   assign bit_pos    = 3'(bits_left - 4'd1);
   assign table_load = code_valid && ((state == IDLE) || (state == DONE));
   assign byte_data  = byte_reg;

   // Map gray value to table entry: values 1..5 pick codes 1..5, others code 6.
   always_comb begin
      sel_idx = 3'd5;
      if (sym_data >= 8'd1 && sym_data <= 8'd5) sel_idx = 3'(sym_data - 8'd1);
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state and handshake outputs.
   always_comb begin
      next_state = state;
      sym_ready  = 1'b0;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:  if (code_valid) next_state = LOAD;
         LOAD:  next_state = READY;
         READY: begin
            sym_ready = 1'b1;
            if (sym_valid) begin
               if (len_tab[sel_idx] != 4'd0) next_state = SHIFT;
               else if (cnt_hit)             next_state = FLUSH;
            end
         end
         SHIFT: begin
            if (byte_full)     next_state = HOLD;
            else if (last_bit) next_state = cnt_hit ? FLUSH : READY;
         end
         HOLD: begin
            byte_valid = 1'b1;
            byte_last  = last_byte;
            if (byte_ready) begin
               if (last_byte)              next_state = DONE;
               else if (bits_left != 4'd0) next_state = SHIFT;
               else                        next_state = READY;
            end
         end
         FLUSH: begin
            if (bitcnt != 3'd0) begin
               byte_valid = 1'b1;
               byte_last  = 1'b1;
               if (byte_ready) next_state = DONE;
            end else begin
               next_state = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (code_valid) next_state = LOAD;
         end
         default: next_state = IDLE;
      endcase
   end

   // Table capture, symbol capture, bit shifting and counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) begin
            hc_tab[i]  <= 8'd0;
            len_tab[i] <= 4'd0;
         end
         cur_code  <= 8'd0;
         bits_left <= 4'd0;
         byte_reg  <= 8'd0;
         bitcnt    <= 3'd0;
         sym_cnt   <= '0;
         last_byte <= 1'b0;
         err       <= 1'b0;
`ifdef HUFF_PACK_BITCNT_EN
         total_bits <= 10'd0;
`endif
      end else begin
         if (table_load) begin
            hc_tab[0]  <= HC1;          hc_tab[1]  <= HC2;
            hc_tab[2]  <= HC3;          hc_tab[3]  <= HC4;
            hc_tab[4]  <= HC5;          hc_tab[5]  <= HC6;
            len_tab[0] <= code_len(M1); len_tab[1] <= code_len(M2);
            len_tab[2] <= code_len(M3); len_tab[3] <= code_len(M4);
            len_tab[4] <= code_len(M5); len_tab[5] <= code_len(M6);
            sym_cnt    <= '0;
            byte_reg   <= 8'd0;
            bitcnt     <= 3'd0;
            bits_left  <= 4'd0;
            last_byte  <= 1'b0;
`ifdef HUFF_PACK_BITCNT_EN
            total_bits <= 10'd0;
`endif
         end
         if (state == READY && sym_valid) begin
            if (len_tab[sel_idx] == 4'd0) begin
               err     <= 1'b1;
               sym_cnt <= sym_cnt + 1'b1;
            end else begin
               cur_code  <= hc_tab[sel_idx];
               bits_left <= len_tab[sel_idx];
            end
         end
         if (state == SHIFT) begin
            byte_reg[3'd7 - bitcnt] <= cur_code[bit_pos];
            bitcnt    <= bitcnt + 3'd1;
            bits_left <= bits_left - 4'd1;
`ifdef HUFF_PACK_BITCNT_EN
            total_bits <= total_bits + 10'd1;
`endif
            if (last_bit) sym_cnt <= sym_cnt + 1'b1;
            if (byte_full && last_bit && cnt_hit) last_byte <= 1'b1;
         end
         if (state == HOLD && byte_ready) byte_reg <= 8'd0;
      end
   end

endmodule
